// File: rtl/dmem_arbiter_if.sv
// Per-master data-memory bus: request payload toward the arbiter,
// grant / read-response back to the master.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            req;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] we;
    logic            gnt;
    logic            rvalid;
    logic [DW-1:0]   rdata;

    modport master (output req, addr, wdata, we, input gnt, rvalid, rdata);
    modport slave  (input req, addr, wdata, we, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read, byte-write data memory
// between two masters. One transaction at a time: writes take 2 cycles
// (IDLE, ACCESS), reads take 4 (IDLE, ACCESS, RDWAIT, RESP).
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   m0,
    dmem_arbiter_if.slave   m1,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_we,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

    state_t          state;
    logic            last;     // id of the master granted most recently
    logic            win;      // id of the master owning the current transaction
    logic            any_req;
    logic            sel;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [DW/8-1:0] sel_we;

    // Pick the winner: a lone requester wins, a tie goes to the master not granted last.
    always_comb begin
        any_req = m0.req | m1.req;
        if (m0.req && m1.req) sel = ~last;
        else                  sel = m1.req;
        sel_addr  = sel ? m1.addr  : m0.addr;
        sel_wdata = sel ? m1.wdata : m0.wdata;
        sel_we    = sel ? m1.we    : m0.we;
    end

    // Transaction FSM; mem_addr/mem_wdata double as the latched payload so they
    // naturally hold their last value outside ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            win       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= '0;
            busy      <= 1'b0;
            m0.gnt    <= 1'b0;
            m1.gnt    <= 1'b0;
            m0.rvalid <= 1'b0;
            m1.rvalid <= 1'b0;
            m0.rdata  <= '0;
            m1.rdata  <= '0;
        end else begin
            m0.gnt    <= 1'b0;
            m1.gnt    <= 1'b0;
            m0.rvalid <= 1'b0;
            m1.rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= ACCESS;
                        busy      <= 1'b1;
                        last      <= sel;
                        win       <= sel;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_we;
                        m0.gnt    <= ~sel;
                        m1.gnt    <= sel;
                    end
                end
                ACCESS: begin
                    // mem_we still holds the latched enables here.
                    mem_we <= '0;
                    if (mem_we != '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (win) m1.rdata <= mem_rdata;
                    else     m0.rdata <= mem_rdata;
                    m0.rvalid <= ~win;
                    m1.rvalid <= win;
                    state     <= RESP;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single transactions against a behavioural
// memory, a read scoreboard, plus reset, contention and abort sequences.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        busy;

    dmem_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
    dmem_arbiter_if #(.AW(32), .DW(32)) m1_bus ();

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .m0(m0_bus.slave), .m1(m1_bus.slave),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous-read, byte-write memory.
    logic [31:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = '0;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= mem[mem_addr[7:2]];
    end

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } sb_t;

    sb_t  sb [$];
    int   checks = 0;
    int   failures = 0;
    logic last_gnt;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic req, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] we);
        if (port) begin
            m1_bus.req = req; m1_bus.addr = addr; m1_bus.wdata = wdata; m1_bus.we = we;
        end else begin
            m0_bus.req = req; m0_bus.addr = addr; m0_bus.wdata = wdata; m0_bus.we = we;
        end
    endtask

    // One transaction from an idle arbiter, with timing checks.
    task automatic do_txn(input vec_t v);
        int   n;
        logic g;
        @(posedge clk); #1;
        drive(v.port, 1'b1, v.addr, v.wdata, v.we);
        n = 0; g = 1'b0;
        while (!g && n < 10) begin
            @(posedge clk); #1;
            n++;
            g = v.port ? m1_bus.gnt : m0_bus.gnt;
        end
        drive(v.port, 1'b0, v.addr, v.wdata, v.we);
        chk("gnt_latency", n, 1);
        if (!g) return;
        chk("other_gnt", v.port ? m0_bus.gnt : m1_bus.gnt, 0);
        chk("mem_we", {28'd0, mem_we}, {28'd0, v.we});
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_wdata", mem_wdata, v.wdata);
        last_gnt = v.port;
        if (v.we != 4'd0) begin
            @(posedge clk); #1;
            chk("wr_idle_busy", busy, 0);
        end else begin
            sb.push_back('{v.port, v.exp_rdata});
            @(posedge clk); #1;
            chk("rdwait_rvalid", v.port ? m1_bus.rvalid : m0_bus.rvalid, 0);
            chk("rdwait_mem_we", {28'd0, mem_we}, 0);
            @(posedge clk); #1;
            chk("resp_rvalid", v.port ? m1_bus.rvalid : m0_bus.rvalid, 1);
            @(posedge clk); #1;
            chk("rd_idle_busy", busy, 0);
        end
    endtask

    // Response monitor: pops the scoreboard on every rvalid and guards exclusivity
    // and the stability of the idle port's rdata.
    initial begin
        logic [31:0] prev0, prev1;
        sb_t e;
        prev0 = '0; prev1 = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("gnt_exclusive", {31'd0, m0_bus.gnt & m1_bus.gnt}, 0);
                chk("rvalid_exclusive", {31'd0, m0_bus.rvalid & m1_bus.rvalid}, 0);
                if (m0_bus.rvalid || m1_bus.rvalid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rvalid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rvalid_port", {31'd0, m1_bus.rvalid}, {31'd0, e.port});
                        chk("rdata", e.port ? m1_bus.rdata : m0_bus.rdata, e.data);
                    end
                end
                if (!m0_bus.rvalid) chk("m0_rdata_stable", m0_bus.rdata, prev0);
                if (!m1_bus.rvalid) chk("m1_rdata_stable", m1_bus.rdata, prev1);
            end
            prev0 = m0_bus.rdata;
            prev1 = m1_bus.rdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_port;
        vecs[0] = '{1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1] = '{1'b1, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 32'h13, 32'hAAAAAAAA, 4'h8, 32'h0};
        vecs[3] = '{1'b0, 32'h10, 32'h0,        4'h0, 32'hAAADBEEF};
        vecs[4] = '{1'b1, 32'h20, 32'h12345678, 4'h3, 32'h0};
        vecs[5] = '{1'b0, 32'h20, 32'h0,        4'h0, 32'h00005678};
        vecs[6] = '{1'b1, 32'h22, 32'hCAFECAFE, 4'hC, 32'h0};
        vecs[7] = '{1'b1, 32'h20, 32'h0,        4'h0, 32'hCAFE5678};

        // Reset held with both masters requesting writes.
        drive(1'b0, 1'b1, 32'h30, 32'h11111111, 4'hF);
        drive(1'b1, 1'b1, 32'h34, 32'h22222222, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m0_gnt", m0_bus.gnt, 0);
        chk("rst_m1_gnt", m1_bus.gnt, 0);
        chk("rst_rvalid", {30'd0, m0_bus.rvalid, m1_bus.rvalid}, 0);
        chk("rst_m0_rdata", m0_bus.rdata, 0);
        chk("rst_m1_rdata", m1_bus.rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we", {28'd0, mem_we}, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("first_tie_m0_gnt", m0_bus.gnt, 1);
        chk("first_tie_m1_gnt", m1_bus.gnt, 0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        last_gnt = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", busy, 0);

        // Single transactions.
        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Contention: both masters hold writes; grants alternate every 2 cycles.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h40, 32'h0000AAAA, 4'hF);
        drive(1'b1, 1'b1, 32'h44, 32'h0000BBBB, 4'hF);
        exp_port = ~last_gnt;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k % 2 == 1) begin
                chk("cont_m0_gnt", m0_bus.gnt, {31'd0, ~exp_port});
                chk("cont_m1_gnt", m1_bus.gnt, {31'd0, exp_port});
                last_gnt = exp_port;
                exp_port = ~exp_port;
            end else begin
                chk("cont_gap", {30'd0, m0_bus.gnt, m1_bus.gnt}, 0);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        chk("cont_idle", busy, 0);

        // Async reset while a read sits in RDWAIT.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
        @(posedge clk); #1;
        chk("abort_gnt", m0_bus.gnt, 1);
        drive(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        @(posedge clk); #1;
        chk("abort_in_rdwait", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_m0_rdata", m0_bus.rdata, 0);
        chk("abort_m1_rdata", m1_bus.rdata, 0);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        last_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("abort_no_rvalid", {30'd0, m0_bus.rvalid, m1_bus.rvalid}, 0);
        end
        do_txn('{1'b1, 32'h10, 32'h0, 4'h0, 32'hAAADBEEF});

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port, byte-write-enabled data memory between the CPU data port (m0) and a second master (m1, DMA/debug loader). A 4-state FSM serialises accesses, grants in round-robin order, drives the memory for exactly one cycle per transaction and returns registered read data to the winning master. It sits between the masters' `daddr`/`dwdata`/`dwe`/`drdata`-style buses and the memory.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width; byte enables are `DW/8` bits wide.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req` / `m1_req`  in  1  transaction request; held high with stable payload until the matching `gnt` pulse.
- `m0_addr` / `m1_addr`  in  AW  byte address.
- `m0_wdata` / `m1_wdata`  in  DW  write data, already lane-replicated by the master.
- `m0_we` / `m1_we`  in  DW/8  byte write enables; all-zero means read.
- `m0_gnt` / `m1_gnt`  out  1  one-cycle pulse: request accepted, payload consumed.
- `m0_rvalid` / `m1_rvalid`  out  1  one-cycle pulse: `rdata` carries read result.
- `m0_rdata` / `m1_rdata`  out  DW  read data, held until that port's next read completes.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_we`  out  DW/8  memory byte write enables.
- `mem_rdata`  in  DW  synchronous-read data, valid the cycle after the address is presented.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACCESS, RDWAIT, RESP.
- IDLE: if no request, stay. If only one master requests, it wins. If both request, the master not granted last wins. Latch winner id, addr, wdata and we into internal registers, then go to ACCESS.
- ACCESS: drive `mem_addr`/`mem_wdata` from the latched registers and `mem_we` = latched we. Pulse the winner's `gnt`. If latched we != 0, go to IDLE. Otherwise go to RDWAIT.
- RDWAIT: `mem_we` = 0. Capture `mem_rdata` into the winner's `rdata` register. Go to RESP.
- RESP: pulse the winner's `rvalid`, then go to IDLE.
- `mem_we` is nonzero only in ACCESS.
- `mem_addr` and `mem_wdata` hold the last latched values in all other states.
- Round-robin pointer `last` updates when entering ACCESS. It resets to 1, so m0 wins the first tie.
- Requests are sampled only in IDLE.
  - A `req` still high in IDLE after its `gnt` counts as a new request.
  - `req` dropped before `gnt` is legal and is simply not served.
- The arbiter passes addresses and enables through; it does no alignment checking or lane decoding.

## Timing
- Reset asserted (low): asynchronously and immediately set state = IDLE, `last` = 1, and all outputs to 0: gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we, busy.
- Reset mid-transaction: the transaction is dropped, with no `gnt` or `rvalid` after release. Writes already in ACCESS are not guaranteed to complete.
- Request sampled in IDLE at cycle t:
  - t+1: ACCESS, `gnt` high.
  - Write: memory written at the end of t+1; IDLE at t+2.
  - Read: `rdata` captured at the end of t+2; `rvalid` high at t+3; IDLE at t+4.
- Throughput: one write per 2 cycles; one read per 4 cycles.
- A request arriving while busy waits. The other master's pending request wins the next IDLE if it was not last granted.
- Only one master's `gnt`/`rvalid` is high in any cycle. The non-selected master's `rdata` never changes.

## Test plan
- Reset: hold `reset`=0 with both req high and we=4'hF. Required: all outputs 0, no `gnt`. Release reset: m0 granted first.
- Single write: m0 req, addr=0x10, wdata=0xDEADBEEF, we=4'hF. Required: `m0_gnt` and mem_we=4'hF one cycle after sampling, then back to IDLE (`busy` low) the following cycle.
- Single read: m1 req, addr=0x10, we=0, memory model returns 0xDEADBEEF. Required: `m1_rvalid` 3 cycles after sampling with m1_rdata=0xDEADBEEF; m0_rdata unchanged.
- Contention: both masters hold writes continuously. Required: grants alternate m0, m1, m0, m1, with one `gnt` every 2 cycles and never both high.
- Byte write: m0 addr=0x13, we=4'b1000, wdata=0xAAAAAAAA. Required: mem_we=4'b1000 for exactly one cycle and mem_addr=0x13.
- Async reset in RDWAIT: pull `reset` low mid-cycle. Required: outputs clear before the next edge; after release, no `rvalid` for the aborted read, and the next request is served normally.
